// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB arbiter: registered one-hot grant, locked tenures, SPLIT masking
// and a hold limit that bounds how long an unlocked master keeps the bus.
module ahb_rr_arbiter #(
  parameter int NUM_MASTERS    = 16,
  parameter int MAX_HOLD       = 16,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [15:0] HBUSREQx,
  input  logic [15:0] HLOCKx,
  input  logic [15:0] HSPLIT,
  input  logic [1:0]  HRESP,
  input  logic        HREADY,
  output logic [15:0] HGRANTx,
  output logic [3:0]  HMASTER,
  output logic        HMASTLOCK
);

  localparam logic [3:0] DEF_MASTER = 4'(DEFAULT_MASTER);
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  logic [15:0] grant_reg, grant_next;
  logic [3:0]  hmaster_reg, hmaster_next;
  logic        hmastlock_reg, hmastlock_next;
  logic [3:0]  data_master_reg, data_master_next;
  logic [15:0] split_mask_reg, split_mask_next;
  logic [3:0]  rr_ptr_reg, rr_ptr_next;
  logic [7:0]  hold_cnt_reg, hold_cnt_next;

  logic [15:0] valid_mask;
  logic [15:0] eligible;
  logic [3:0]  owner_idx;
  logic        owner_valid;
  logic        others_eligible;
  logic        rearb;
  logic        winner_found;
  logic [3:0]  winner_idx;
  logic [3:0]  cand;
  int          start_off;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_valid
      assign valid_mask[gi] = (gi < NUM_MASTERS);
    end
  endgenerate

  assign eligible        = HBUSREQx & ~split_mask_reg & valid_mask;
  assign owner_valid     = |grant_reg;
  assign others_eligible = |(eligible & ~grant_reg);

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (grant_reg[i]) owner_idx = 4'(i);
    end
  end

  // A locked, still-requesting owner is exempt from the hold limit.
  assign rearb = !owner_valid
              || !HBUSREQx[owner_idx]
              || split_mask_reg[owner_idx]
              || (!HLOCKx[owner_idx] && others_eligible && (hold_cnt_reg >= HOLD_LIMIT));

  // With a live owner the search starts after rr_ptr (the owner is tried last);
  // from an idle bus it starts at rr_ptr itself, so DEFAULT_MASTER leads after reset.
  always_comb begin
    winner_found = 1'b0;
    winner_idx   = rr_ptr_reg;
    cand         = '0;
    start_off    = owner_valid ? 1 : 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = 4'((int'(rr_ptr_reg) + start_off + k) % NUM_MASTERS);
      if (!winner_found && eligible[cand]) begin
        winner_found = 1'b1;
        winner_idx   = cand;
      end
    end
  end

  always_comb begin
    grant_next       = grant_reg;
    rr_ptr_next      = rr_ptr_reg;
    hold_cnt_next    = hold_cnt_reg;
    hmaster_next     = hmaster_reg;
    hmastlock_next   = hmastlock_reg;
    data_master_next = data_master_reg;
    if (HREADY) begin
      if (rearb) begin
        grant_next = winner_found ? (16'd1 << winner_idx) : 16'd0;
        if (winner_found) rr_ptr_next = winner_idx;
      end
      if (grant_next != grant_reg)  hold_cnt_next = '0;
      else if (hold_cnt_reg != 8'hFF) hold_cnt_next = hold_cnt_reg + 8'd1;
      hmaster_next     = owner_valid ? owner_idx : DEF_MASTER;
      hmastlock_next   = owner_valid & HLOCKx[owner_idx];
      data_master_next = hmaster_reg;
    end

    // Set is applied after clear so a coincident SPLIT keeps the master masked.
    split_mask_next = split_mask_reg & ~HSPLIT;
    if (HRESP == 2'b11 && !HREADY) split_mask_next[data_master_reg] = 1'b1;
    split_mask_next = split_mask_next & valid_mask;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      grant_reg       <= '0;
      hmaster_reg     <= DEF_MASTER;
      hmastlock_reg   <= 1'b0;
      data_master_reg <= DEF_MASTER;
      split_mask_reg  <= '0;
      rr_ptr_reg      <= DEF_MASTER;
      hold_cnt_reg    <= '0;
    end else begin
      grant_reg       <= grant_next;
      hmaster_reg     <= hmaster_next;
      hmastlock_reg   <= hmastlock_next;
      data_master_reg <= data_master_next;
      split_mask_reg  <= split_mask_next;
      rr_ptr_reg      <= rr_ptr_next;
      hold_cnt_reg    <= hold_cnt_next;
    end
  end

  assign HGRANTx   = grant_reg;
  assign HMASTER   = hmaster_reg;
  assign HMASTLOCK = hmastlock_reg;

endmodule
